// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
// Optional feature macro: BIN2BCD_SAT_EN (saturate out-of-range results to 9999).
package bcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SHIFT = 3'b010,
        S_DONE  = 3'b100
    } bcd_state_t;

    localparam int unsigned BCD_MAX    = 9999;
    localparam logic [15:0] BCD_SAT    = 16'h9999;
    localparam logic [15:0] BCD_ERR    = 16'hFFFF;
    localparam int          BCD_DIGITS = 4;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD nibble pre-shift correction: add 3 when the digit is 5 or more.
// Inputs are always <= 9, so the 4-bit add never carries out.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Combinational +3 correction.
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Macro BIN2BCD_SAT_EN: out-of-range loads 16'h9999 instead of 16'hFFFF.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic            clk,
    input  logic            reset_p,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic [15:0]     bcd_out,
    output logic            ovf
);

    localparam int CNT_W = (IN_W < 2) ? 1 : $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
    localparam int SR_W = 16 + IN_W;

    bcd_state_t       state_q;
    bcd_state_t       state_d;
    logic             load;
    logic             shift;
    logic             fin;
    logic [CNT_W-1:0] cnt;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  pre;
    logic [15:0]      adj;
    logic             ovf_pending;
    logic             ovf_in;
    logic [15:0]      result;

    // Comparison only matters when the input can exceed 9999.
    assign ovf_in = (IN_W >= 14) && (32'(bin_in) > BCD_MAX);

    genvar g;
    generate
        for (g = 0; g < BCD_DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .d (sr[IN_W + 4*g +: 4]),
                .q (adj[4*g +: 4])
            );
        end
    endgenerate

    assign pre    = {adj, sr[IN_W-1:0]};
    assign result = sr[SR_W-1:IN_W];

    // State register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                fin     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shift register, bit counter and pending overflow flag.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sr          <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
        end else if (load) begin
            sr          <= {16'h0000, bin_in};
            cnt         <= '0;
            ovf_pending <= ovf_in;
        end else if (shift) begin
            sr  <= pre << 1;
            cnt <= cnt + 1'b1;
        end
    end

    // Registered handshake and result outputs; results hold between pulses.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= 16'h0000;
            ovf     <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= fin;
            if (fin) begin
                ovf <= ovf_pending;
`ifdef BIN2BCD_SAT_EN
                bcd_out <= ovf_pending ? BCD_SAT : result;
`else
                bcd_out <= ovf_pending ? BCD_ERR : result;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (IN_W=14 and IN_W=9 instances).
// Expected results come from a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin_in = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    logic        start9 = 1'b0;
    logic [8:0]  bin9 = '0;
    logic        busy9;
    logic        done9;
    logic [15:0] bcd9;
    logic        ovf9;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.IN_W(14)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    bin_to_bcd_seq #(.IN_W(9)) dut9 (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (start9),
        .bin_in  (bin9),
        .busy    (busy9),
        .done    (done9),
        .bcd_out (bcd9),
        .ovf     (ovf9)
    );

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) begin
`ifdef BIN2BCD_SAT_EN
            return 16'h9999;
`else
            return 16'hFFFF;
`endif
        end
        return {4'(v / 1000), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion on the 14-bit DUT starting in the current cycle.
    task automatic do_conv(input int v, output int lat,
                           output int bcyc, output logic [15:0] res,
                           output logic o);
        start  = 1'b1;
        bin_in = 14'(v);
        tick();
        start  = 1'b0;
        bin_in = 14'($urandom);
        lat    = 0;
        bcyc   = busy ? 1 : 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) bcyc++;
        end
        res = bcd_out;
        o   = ovf;
    endtask

    task automatic check_conv(input string name, input int v);
        int lat;
        int bcyc;
        logic [15:0] res;
        logic o;
        do_conv(v, lat, bcyc, res, o);
        total++;
        if (lat != 15) begin
            bad++;
            $display("FAIL %s latency got=%0d want=15", name, lat);
        end
        total++;
        if (res !== ref_bcd(v)) begin
            bad++;
            $display("FAIL %s bcd got=%h want=%h", name, res, ref_bcd(v));
        end
        total++;
        if (o !== (v > 9999)) begin
            bad++;
            $display("FAIL %s ovf got=%b want=%b", name, o, v > 9999);
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, done, bcd_out, ovf} !== 19'h0) begin
            bad++;
            $display("FAIL reset got=%b/%b/%h/%b want=0/0/0000/0",
                     busy, done, bcd_out, ovf);
        end
        reset_p = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        int bcyc;
        logic [15:0] res;
        logic o;
        do_conv(1234, lat, bcyc, res, o);
        total++;
        if (lat != 15) begin
            bad++;
            $display("FAIL basic latency got=%0d want=15", lat);
        end
        total++;
        if (bcyc != 15) begin
            bad++;
            $display("FAIL basic busy_cycles got=%0d want=15", bcyc);
        end
        total++;
        if (res !== 16'h1234 || o !== 1'b0) begin
            bad++;
            $display("FAIL basic result got=%h/%b want=1234/0", res, o);
        end
        tick();
        total++;
        if (done !== 1'b0 || bcd_out !== 16'h1234) begin
            bad++;
            $display("FAIL basic hold got=%b/%h want=0/1234", done, bcd_out);
        end
    endtask

    task automatic test_boundaries();
        check_conv("zero", 0);
        check_conv("max", 9999);
        check_conv("seven", 7);
    endtask

    task automatic test_ovf();
        check_conv("ovf10000", 10000);
        check_conv("ovf16383", 16383);
        check_conv("after_ovf", 42);
    endtask

    task automatic test_ignored_start();
        int ndone = 0;
        start  = 1'b1;
        bin_in = 14'd500;
        tick();
        start = 1'b0;
        tick();
        tick();
        start  = 1'b1;
        bin_in = 14'd321;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            tick();
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL ignored_start dones got=%0d want=1", ndone);
        end
        total++;
        if (bcd_out !== 16'h0500) begin
            bad++;
            $display("FAIL ignored_start bcd got=%h want=0500", bcd_out);
        end
    endtask

    task automatic test_back_to_back();
        check_conv("b2b_a", 777);
        check_conv("b2b_b", 321);
        check_conv("b2b_c", 10001);
        check_conv("b2b_d", 9);
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        start  = 1'b1;
        bin_in = 14'd8888;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset_p = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || bcd_out !== 16'h0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got=%b/%h/%b want=0/0000/0",
                     busy, bcd_out, done);
        end
        tick();
        reset_p = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) ndone++;
            tick();
        end
        total++;
        if (ndone != 0 || bcd_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid after got=%0d/%h want=0/0000",
                     ndone, bcd_out);
        end
        check_conv("post_reset", 56);
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 25; i++) begin
            v = (i % 5 == 0) ? int'($urandom_range(9990, 16383))
                             : int'($urandom_range(0, 9999));
            check_conv($sformatf("rand%0d_%0d", i, v), v);
        end
    endtask

    task automatic test_narrow();
        int vals[$];
        int lat;
        vals.push_back(400);
        vals.push_back(511);
        vals.push_back(0);
        for (int i = 0; i < 4; i++) vals.push_back(int'($urandom_range(0, 511)));
        foreach (vals[k]) begin
            start9 = 1'b1;
            bin9   = 9'(vals[k]);
            tick();
            start9 = 1'b0;
            lat    = 0;
            while (!done9 && lat < 40) begin
                tick();
                lat++;
            end
            total++;
            if (lat != 10) begin
                bad++;
                $display("FAIL narrow%0d latency got=%0d want=10", k, lat);
            end
            total++;
            if (bcd9 !== ref_bcd(vals[k]) || ovf9 !== 1'b0) begin
                bad++;
                $display("FAIL narrow%0d got=%h/%b want=%h/0",
                         k, bcd9, ovf9, ref_bcd(vals[k]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ovf();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
